uart_bus_ctrl: RTL and testbench

//  Bus-side controller for the UART datapath, in the clk_bus domain. Drains uart_rx
//  (data/data_available/clear handshake) into an RX FIFO, sequences uart_tx byte

---
 rtl/uart_bus_ctrl_if.sv | 26 ++
 rtl/uart_bus_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_bus_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_ctrl_if.sv
// CPU bus plus uart_rx / uart_tx handshake bundle for uart_bus_ctrl.
// The controller connects through the slave modport; the driving side uses master.
interface uart_bus_ctrl_if;
  logic [1:0] bus_addr;
  logic       bus_rd;
  logic       bus_wr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_clear;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       irq;

  modport master (
    output bus_addr, bus_rd, bus_wr, bus_wdata, rx_data, rx_avail, tx_busy,
    input  bus_rdata, rx_clear, tx_data, tx_start, irq
  );

  modport slave (
    input  bus_addr, bus_rd, bus_wr, bus_wdata, rx_data, rx_avail, tx_busy,
    output bus_rdata, rx_clear, tx_data, tx_start, irq
  );
endinterface

// File: rtl/uart_bus_ctrl.sv
// Bus-side UART controller: drains uart_rx into an RX FIFO, launches uart_tx
// bytes from a holding register, and exposes DATA/STATUS/CTRL plus irq.
module uart_bus_ctrl #(
  parameter int unsigned FIFO_AW = 4
) (
  input logic          clk_bus,
  input logic          rst,
  uart_bus_ctrl_if.slave bus
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [0:0] {R_IDLE, R_WAIT} rx_state_e;
  typedef enum logic [1:0] {T_IDLE, T_ACK, T_BUSY} tx_state_e;

  rx_state_e rx_state_q, rx_state_d;
  tx_state_e tx_state_q, tx_state_d;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               rx_unf_q, rx_unf_d, tx_ovr_q, tx_ovr_d;
  logic [7:0]         bus_rdata_q, bus_rdata_d;
  logic               rx_clear_q, rx_clear_d, tx_start_q, tx_start_d, irq_q, irq_d;

  logic rx_ne, rx_full, tx_rdy, push, pop, launch, tx_done;
  logic rd_data, rd_status, wr_data, wr_ctrl;
  logic [7:0] status;

  assign rx_ne     = (count_q != '0);
  assign rx_full   = (count_q == FULL_CNT);
  assign tx_rdy    = !hold_full_q && (tx_state_q == T_IDLE);
  assign status    = {3'b000, rx_unf_q, tx_ovr_q, rx_full, tx_rdy, rx_ne};
  assign rd_data   = bus.bus_rd && (bus.bus_addr == 2'd0);
  assign rd_status = bus.bus_rd && (bus.bus_addr == 2'd1);
  assign wr_data   = bus.bus_wr && (bus.bus_addr == 2'd0);
  assign wr_ctrl   = bus.bus_wr && (bus.bus_addr == 2'd2);
  assign pop       = rd_data && rx_ne;

  // State registers
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      rx_state_q <= R_IDLE;
      tx_state_q <= T_IDLE;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      R_IDLE:  if (bus.rx_avail && !rx_full) rx_state_d = R_WAIT;
      R_WAIT:  if (!bus.rx_avail) rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      T_IDLE:  if (hold_full_q && !bus.tx_busy) tx_state_d = T_ACK;
      T_ACK:   if (bus.tx_busy) tx_state_d = T_BUSY;
      T_BUSY:  if (!bus.tx_busy) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  // FSM outputs; fullness is sampled at cycle start so a same-cycle pop never admits a push
  always_comb begin
    push    = (rx_state_q == R_IDLE) && bus.rx_avail && !rx_full;
    launch  = (tx_state_q == T_IDLE) && hold_full_q && !bus.tx_busy;
    tx_done = (tx_state_q == T_BUSY) && !bus.tx_busy;
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (tx_done) hold_full_d = 1'b0;
    if (wr_data && tx_rdy) begin
      hold_d      = bus.bus_wdata;
      hold_full_d = 1'b1;
    end
    ctrl_d      = wr_ctrl ? bus.bus_wdata[1:0] : ctrl_q;
    rx_unf_d    = (rx_unf_q && !rd_status) || (rd_data && !rx_ne);
    tx_ovr_d    = (tx_ovr_q && !rd_status) || (wr_data && !tx_rdy);
    bus_rdata_d = bus_rdata_q;
    if (bus.bus_rd) begin
      unique case (bus.bus_addr)
        2'd0:    bus_rdata_d = rx_ne ? mem_q[rd_ptr_q] : '0;
        2'd1:    bus_rdata_d = status;
        2'd2:    bus_rdata_d = {6'b000000, ctrl_q};
        default: bus_rdata_d = '0;
      endcase
    end
    rx_clear_d  = push;
    tx_start_d  = launch;
    irq_d       = (rx_ne && ctrl_q[0]) || (tx_rdy && ctrl_q[1]);
  end

  always_ff @(posedge clk_bus) begin
    if (push) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ctrl_q      <= '0;
      rx_unf_q    <= 1'b0;
      tx_ovr_q    <= 1'b0;
      bus_rdata_q <= '0;
      rx_clear_q  <= 1'b0;
      tx_start_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ctrl_q      <= ctrl_d;
      rx_unf_q    <= rx_unf_d;
      tx_ovr_q    <= tx_ovr_d;
      bus_rdata_q <= bus_rdata_d;
      rx_clear_q  <= rx_clear_d;
      tx_start_q  <= tx_start_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.bus_rdata = bus_rdata_q;
  assign bus.rx_clear  = rx_clear_q;
  assign bus.tx_data   = hold_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.irq       = irq_q;
endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Directed self-checking bench for uart_bus_ctrl: RX drain and backpressure,
// TX launch handshake, sticky flags, register map, irq and reset.
module tb_uart_bus_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  uart_bus_ctrl_if bus_if();

  uart_bus_ctrl #(.FIFO_AW(4)) dut (
    .clk_bus (clk),
    .rst     (rst),
    .bus     (bus_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    bus_if.bus_addr = a;
    bus_if.bus_rd   = 1'b1;
    tick();
    bus_if.bus_rd   = 1'b0;
    d = bus_if.bus_rdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = d;
    bus_if.bus_wr    = 1'b1;
    tick();
    bus_if.bus_wr    = 1'b0;
  endtask

  // Offers one byte to the controller; ok=1 if rx_clear was seen within the bound.
  task automatic rx_push(input logic [7:0] b, output logic ok);
    ok = 1'b0;
    bus_if.rx_data  = b;
    bus_if.rx_avail = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus_if.rx_clear === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    bus_if.rx_avail = 1'b0;
    tick();
  endtask

  task automatic wait_tx_start(output logic found);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus_if.tx_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [19:0] outs;
    #3;
    outs = {bus_if.bus_rdata, bus_if.rx_clear, bus_if.tx_data, bus_if.tx_start, bus_if.irq};
    checks++;
    if (outs !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 00000", outs);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rx_basic();
    logic ok;
    logic [7:0] d;
    rx_push(8'hA5, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL rx_clear_pulse: got %b, expected 1", ok); end
    checks++;
    if (bus_if.rx_clear !== 1'b0) begin errors++; $display("FAIL rx_clear_width: got %b, expected 0", bus_if.rx_clear); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h03) begin errors++; $display("FAIL rx_status_ne: got %h, expected 03", d); end
    bus_read(2'd0, d);
    checks++;
    if (d !== 8'hA5) begin errors++; $display("FAIL rx_data: got %h, expected a5", d); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL rx_status_empty: got %h, expected 02", d); end
  endtask

  task automatic test_rx_full();
    logic ok;
    logic [7:0] d;
    int unsigned n_ok = 0;
    int unsigned bad = 0;
    logic clr_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rx_push(8'(i), ok);
      if (ok === 1'b1) n_ok++;
    end
    checks++;
    if (n_ok != 16) begin errors++; $display("FAIL fill_accepts: got %0d, expected 16", n_ok); end
    bus_if.rx_data  = 8'h10;
    bus_if.rx_avail = 1'b1;
    repeat (4) begin
      tick();
      if (bus_if.rx_clear !== 1'b0) clr_seen = 1'b1;
    end
    bus_read(2'd1, d);
    if (bus_if.rx_clear !== 1'b0) clr_seen = 1'b1;
    checks++;
    if (d !== 8'h07) begin errors++; $display("FAIL full_status: got %h, expected 07", d); end
    checks++;
    if (clr_seen !== 1'b0) begin errors++; $display("FAIL full_backpressure: got rx_clear=1, expected 0"); end
    bus_read(2'd0, d);
    checks++;
    if (d !== 8'h00 || bus_if.rx_clear !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_first: got data=%h clear=%b, expected 00/0", d, bus_if.rx_clear);
    end
    tick();
    checks++;
    if (bus_if.rx_clear !== 1'b1) begin errors++; $display("FAIL full_late_push: got %b, expected 1", bus_if.rx_clear); end
    bus_if.rx_avail = 1'b0;
    tick();
    for (int i = 1; i <= 16; i++) begin
      bus_read(2'd0, d);
      if (d !== 8'(i)) begin
        if (bad == 0) $display("FAIL drain_order: read %0d got %h, expected %h", i, d, 8'(i));
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL drain_status: got %h, expected 02", d); end
  endtask

  task automatic test_tx();
    logic found;
    logic [7:0] d;
    int unsigned starts = 0;
    int unsigned bad_data = 0;
    bus_write(2'd0, 8'h55);
    wait_tx_start(found);
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL tx_launch: got no tx_start, expected one"); end
    if (found === 1'b1) starts++;
    checks++;
    if (bus_if.tx_data !== 8'h55) begin errors++; $display("FAIL tx_data_launch: got %h, expected 55", bus_if.tx_data); end
    repeat (2) begin
      tick();
      if (bus_if.tx_start === 1'b1) starts++;
    end
    bus_if.tx_busy = 1'b1;
    repeat (100) begin
      tick();
      if (bus_if.tx_start === 1'b1) starts++;
      if (bus_if.tx_data !== 8'h55) bad_data++;
    end
    checks++;
    if (bad_data != 0) begin errors++; $display("FAIL tx_data_hold: got %0d unstable cycles, expected 0", bad_data); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL tx_busy_status: got %h, expected 00", d); end
    bus_if.tx_busy = 1'b0;
    repeat (4) begin
      tick();
      if (bus_if.tx_start === 1'b1) starts++;
    end
    checks++;
    if (starts != 1) begin errors++; $display("FAIL tx_start_count: got %0d, expected 1", starts); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL tx_rdy_after: got %h, expected 02", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    bus_write(2'd0, 8'hAA);
    bus_write(2'd0, 8'hBB);
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h08) begin errors++; $display("FAIL ovr_status: got %h, expected 08", d); end
    checks++;
    if (bus_if.tx_data !== 8'hAA) begin errors++; $display("FAIL ovr_kept_first: got %h, expected aa", bus_if.tx_data); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ovr_cleared: got %h, expected 00", d); end
    bus_if.tx_busy = 1'b1;
    repeat (2) tick();
    bus_if.tx_busy = 1'b0;
    repeat (2) tick();
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL ovr_tx_done: got %h, expected 02", d); end
  endtask

  task automatic test_underflow();
    logic [7:0] d;
    bus_if.rx_data  = 8'h3C;
    bus_if.rx_avail = 1'b1;
    bus_read(2'd0, d);
    checks++;
    if (d !== 8'h00 || bus_if.rx_clear !== 1'b1) begin
      errors++;
      $display("FAIL unf_read: got data=%h clear=%b, expected 00/1", d, bus_if.rx_clear);
    end
    bus_if.rx_avail = 1'b0;
    tick();
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h13) begin errors++; $display("FAIL unf_status: got %h, expected 13", d); end
    bus_read(2'd0, d);
    checks++;
    if (d !== 8'h3C) begin errors++; $display("FAIL unf_byte_kept: got %h, expected 3c", d); end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL unf_cleared: got %h, expected 02", d); end
  endtask

  task automatic test_regs();
    logic [7:0] d;
    bus_write(2'd2, 8'hFF);
    bus_read(2'd2, d);
    checks++;
    if (d !== 8'h03) begin errors++; $display("FAIL ctrl_readback: got %h, expected 03", d); end
    bus_read(2'd3, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL addr3_read: got %h, expected 00", d); end
    bus_write(2'd1, 8'hFF);
    bus_write(2'd3, 8'h55);
    repeat (3) tick();
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL ignored_writes_status: got %h, expected 02", d); end
    bus_read(2'd2, d);
    checks++;
    if (d !== 8'h03) begin errors++; $display("FAIL ignored_writes_ctrl: got %h, expected 03", d); end
    checks++;
    if (bus_if.irq !== 1'b1) begin errors++; $display("FAIL irq_tx_ie: got %b, expected 1", bus_if.irq); end
    bus_write(2'd2, 8'h00);
    repeat (2) tick();
    checks++;
    if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: got %b, expected 0", bus_if.irq); end
  endtask

  task automatic test_irq_reset();
    logic ok, found;
    logic [7:0] d;
    logic [19:0] outs;
    bus_write(2'd2, 8'h01);
    tick();
    checks++;
    if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b, expected 0", bus_if.irq); end
    rx_push(8'h77, ok);
    checks++;
    if (bus_if.irq !== 1'b1) begin errors++; $display("FAIL irq_rx: got %b, expected 1", bus_if.irq); end
    bus_read(2'd0, d);
    checks++;
    if (d !== 8'h77) begin errors++; $display("FAIL irq_rx_data: got %h, expected 77", d); end
    tick();
    checks++;
    if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL irq_drained: got %b, expected 0", bus_if.irq); end
    rx_push(8'h11, ok);
    bus_read(2'd2, d);
    bus_write(2'd0, 8'h99);
    wait_tx_start(found);
    bus_if.tx_busy = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus_if.tx_data !== 8'h99 || bus_if.irq !== 1'b1 || bus_if.bus_rdata !== 8'h01) begin
      errors++;
      $display("FAIL pre_reset: got tx_data=%h irq=%b rdata=%h, expected 99/1/01",
               bus_if.tx_data, bus_if.irq, bus_if.bus_rdata);
    end
    #2;
    rst = 1'b1;
    #1;
    outs = {bus_if.bus_rdata, bus_if.rx_clear, bus_if.tx_data, bus_if.tx_start, bus_if.irq};
    checks++;
    if (outs !== 20'h0) begin errors++; $display("FAIL mid_tx_reset: got %h, expected 00000", outs); end
    bus_if.tx_busy = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL post_reset_status: got %h, expected 02", d); end
  endtask

  initial begin
    bus_if.bus_addr  = 2'd0;
    bus_if.bus_rd    = 1'b0;
    bus_if.bus_wr    = 1'b0;
    bus_if.bus_wdata = 8'h00;
    bus_if.rx_data   = 8'h00;
    bus_if.rx_avail  = 1'b0;
    bus_if.tx_busy   = 1'b0;
    test_reset();
    test_rx_basic();
    test_rx_full();
    test_tx();
    test_back_to_back();
    test_underflow();
    test_regs();
    test_irq_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
